// File: rtl/afifo_rd_ctrl.sv
// Read-side pointer controller for a dual-clock gray-pointer FIFO.
// Synchronizes the write gray pointer and derives empty, almost-empty, fill level and underflow.
module afifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH:0]   wptr_gray_async,
   input  logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH:0]   rptr_gray,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_level,
   output logic                  underflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // XOR prefix from the MSB down
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] wsync1_r;
   logic [PW-1:0] wsync2_r;
   logic [PW-1:0] rbin_r;
   logic [PW-1:0] rgray_r;
   logic [PW-1:0] level_r;
   logic          empty_r;
   logic          ae_r;
   logic          uf_r;

   logic          rd_fire_s;
   logic [PW-1:0] rbin_next_s;
   logic [PW-1:0] rgray_next_s;
   logic [PW-1:0] wbin_s;
   logic [PW-1:0] level_next_s;

   // Next read pointer and next fill level from the synchronized write pointer
   always_comb begin
      rd_fire_s    = rd_en & ~empty_r;
      rbin_next_s  = rbin_r;
      if (rd_fire_s) begin
         rbin_next_s = rbin_r + PW'(1);
      end else begin
         rbin_next_s = rbin_r;
      end
      rgray_next_s = bin2gray(rbin_next_s);
      wbin_s       = gray2bin(wsync2_r);
      level_next_s = wbin_s - rbin_next_s;
   end

   // Two-flop synchronizer for the write-domain gray pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wsync1_r <= {PW{1'b0}};
         wsync2_r <= {PW{1'b0}};
      end else begin
         wsync1_r <= wptr_gray_async;
         wsync2_r <= wsync1_r;
      end
   end

   // Read pointer and flags; flags use the next pointer so a pop updates them on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbin_r  <= {PW{1'b0}};
         rgray_r <= {PW{1'b0}};
         level_r <= {PW{1'b0}};
         empty_r <= 1'b1;
         ae_r    <= 1'b1;
         uf_r    <= 1'b0;
      end else begin
         rbin_r  <= rbin_next_s;
         rgray_r <= rgray_next_s;
         level_r <= level_next_s;
         empty_r <= (rgray_next_s == wsync2_r);
         ae_r    <= (level_next_s <= AE_LVL);
         uf_r    <= rd_en & empty_r;
      end
   end

   assign rd_addr      = rbin_r[ADDR_WIDTH-1:0];
   assign rptr_gray    = rgray_r;
   assign empty        = empty_r;
   assign almost_empty = ae_r;
   assign rd_level     = level_r;
   assign underflow    = uf_r;

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Directed self-checking bench for afifo_rd_ctrl (ADDR_WIDTH=4, AE_THRESH=2).
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_afifo_rd_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] wptr_gray_async;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic [4:0] rptr_gray;
   logic       empty;
   logic       almost_empty;
   logic [4:0] rd_level;
   logic       underflow;

   int n_checks;
   int n_errors;

   afifo_rd_ctrl #(.ADDR_WIDTH(4), .AE_THRESH(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .wptr_gray_async (wptr_gray_async),
      .rd_en           (rd_en),
      .rd_addr         (rd_addr),
      .rptr_gray       (rptr_gray),
      .empty           (empty),
      .almost_empty    (almost_empty),
      .rd_level        (rd_level),
      .underflow       (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [4:0] gray5(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      rd_en           = 1'b0;
      wptr_gray_async = 5'd0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int         wr;
      int         pops;
      int         ntog;
      int         tog_at [2];
      logic [4:0] prev;
      logic [4:0] diff;

      n_checks        = 0;
      n_errors        = 0;
      rst_n           = 1'b0;
      rd_en           = 1'b0;
      wptr_gray_async = 5'd0;

      // Reset held while the write pointer moves
      tick();
      wptr_gray_async = gray5(5'd5);
      tick();
      wptr_gray_async = gray5(5'd9);
      tick();
      check_eq("rst_empty", 32'(empty), 32'd1);
      check_eq("rst_ae", 32'(almost_empty), 32'd1);
      check_eq("rst_level", 32'(rd_level), 32'd0);
      check_eq("rst_rptr", 32'(rptr_gray), 32'd0);
      check_eq("rst_uf", 32'(underflow), 32'd0);
      wptr_gray_async = 5'd0;
      rst_n = 1'b1;
      tick();
      tick();

      // Write pointer 0 -> 3, visible after two sync edges plus the flag edge
      wptr_gray_async = gray5(5'd3);
      tick();
      tick();
      check_eq("lat_empty_n1", 32'(empty), 32'd1);
      tick();
      check_eq("lat_empty_n2", 32'(empty), 32'd0);
      check_eq("lat_level", 32'(rd_level), 32'd3);
      check_eq("lat_ae", 32'(almost_empty), 32'd0);

      // Three pops drain the FIFO
      check_eq("pop_addr0", 32'(rd_addr), 32'd0);
      rd_en = 1'b1;
      tick();
      check_eq("pop_addr1", 32'(rd_addr), 32'd1);
      check_eq("pop_level2", 32'(rd_level), 32'd2);
      check_eq("pop_ae_at_thresh", 32'(almost_empty), 32'd1);
      check_eq("pop_empty1", 32'(empty), 32'd0);
      tick();
      check_eq("pop_addr2", 32'(rd_addr), 32'd2);
      check_eq("pop_level1", 32'(rd_level), 32'd1);
      tick();
      check_eq("drain_empty", 32'(empty), 32'd1);
      check_eq("drain_level", 32'(rd_level), 32'd0);
      check_eq("drain_rptr", 32'(rptr_gray), 32'(gray5(5'd3)));
      check_eq("drain_uf", 32'(underflow), 32'd0);

      // Pop while empty: underflow pulse, pointer held
      tick();
      check_eq("uf_pulse", 32'(underflow), 32'd1);
      check_eq("uf_rptr", 32'(rptr_gray), 32'(gray5(5'd3)));
      check_eq("uf_addr", 32'(rd_addr), 32'd3);
      rd_en = 1'b0;
      tick();
      check_eq("uf_clear", 32'(underflow), 32'd0);
      check_eq("uf_rptr2", 32'(rptr_gray), 32'(gray5(5'd3)));

      // Wrap: 40 words streamed, reader pops whenever non-empty
      do_reset();
      wr   = 0;
      pops = 0;
      ntog = 0;
      tog_at[0] = 0;
      tog_at[1] = 0;
      prev = rptr_gray;
      for (int cyc = 0; cyc < 300 && pops < 40; cyc++) begin
         if (wr < 40) wr++;
         wptr_gray_async = gray5(5'(wr));
         rd_en = ~empty;
         tick();
         if (rptr_gray !== prev) begin
            pops++;
            diff = rptr_gray ^ prev;
            check_eq("wrap_onebit", 32'($countones(diff)), 32'd1);
            check_eq("wrap_rptr", 32'(rptr_gray), 32'(gray5(5'(pops))));
            if (diff[4]) begin
               if (ntog < 2) tog_at[ntog] = pops;
               ntog++;
            end
            prev = rptr_gray;
         end
      end
      rd_en = 1'b0;
      check_eq("wrap_pops", 32'(pops), 32'd40);
      tick();
      tick();
      tick();
      tick();
      check_eq("wrap_empty", 32'(empty), 32'd1);
      check_eq("wrap_level", 32'(rd_level), 32'd0);
      check_eq("wrap_ntog", 32'(ntog), 32'd2);
      check_eq("wrap_tog16", 32'(tog_at[0]), 32'd16);
      check_eq("wrap_tog32", 32'(tog_at[1]), 32'd32);
      check_eq("wrap_final_rptr", 32'(rptr_gray), 32'(gray5(5'd8)));

      // Full: level 16 must not read as empty; then reset mid-stream
      do_reset();
      wptr_gray_async = gray5(5'd16);
      tick();
      tick();
      tick();
      check_eq("full_empty", 32'(empty), 32'd0);
      check_eq("full_level", 32'(rd_level), 32'd16);
      check_eq("full_ae", 32'(almost_empty), 32'd0);
      rd_en = 1'b1;
      tick();
      check_eq("full_pop_level", 32'(rd_level), 32'd15);
      check_eq("full_pop_rptr", 32'(rptr_gray), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_empty", 32'(empty), 32'd1);
      check_eq("mid_rst_ae", 32'(almost_empty), 32'd1);
      check_eq("mid_rst_level", 32'(rd_level), 32'd0);
      check_eq("mid_rst_rptr", 32'(rptr_gray), 32'd0);
      check_eq("mid_rst_addr", 32'(rd_addr), 32'd0);
      check_eq("mid_rst_uf", 32'(underflow), 32'd0);
      tick();
      rd_en = 1'b0;
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
